tournament_predictor_param: RTL and testbench

Parametrised tournament branch-direction predictor: successor of the fixed 5-bit tournament predictor, generalised in PC width, history lengths and counter width, with an explicit predict/update interface.
- Sits beside the fetch stage and combines a per-branch local-history predictor, a gshare-style global predictor and a chooser table.
- Produces a registered taken/not-taken prediction with its source.
- Trains on resolved branches, whose direction is derived from the effective address.

---
 rtl/tournament_predictor_param.sv | 157 +++++++++++++++
 tb/tb_tournament_predictor_param.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tournament_predictor_param.sv
// rtl/tournament_predictor_param.sv - parametrised tournament branch-direction predictor
//
// Purpose: combines a per-branch local-history predictor, a gshare-style
// global predictor and a chooser table. It produces a registered prediction
// one cycle after a request. It trains on resolved branches. A branch is
// treated as taken when its effective address is below its PC (a backward
// branch).
//
// Optional feature: define TP_STATS_EN to add the saturating statistics
// outputs stat_upd_o / stat_mispred_o.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   pred_valid_i   in   prediction request
//   pred_pc_i      in   PC of branch to predict
//   pred_valid_o   out  registered pred_valid_i
//   pred_taken_o   out  predicted direction (1 = taken), held between requests
//   pred_src_o     out  0 = local component used, 1 = global component used
//   upd_valid_i    in   resolved branch update
//   upd_pc_i       in   PC of resolved branch
//   upd_target_i   in   effective address of resolved branch
//   stat_upd_o     out  (TP_STATS_EN) number of update cycles
//   stat_mispred_o out  (TP_STATS_EN) updates whose recomputed prediction was wrong
module tournament_predictor_param #(
  parameter int PC_W      = 5,
  parameter int LHT_IDX_W = 3,
  parameter int LHIST_W   = 4,
  parameter int GHIST_W   = 4,
  parameter int CTR_W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid_i,
  input  logic [PC_W-1:0]  pred_pc_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  output logic             pred_src_o,
  input  logic             upd_valid_i,
  input  logic [PC_W-1:0]  upd_pc_i,
  input  logic [PC_W-1:0]  upd_target_i
`ifdef TP_STATS_EN
  ,
  output logic [15:0]      stat_upd_o,
  output logic [15:0]      stat_mispred_o
`endif
);

  localparam int LHT_N  = 1 << LHT_IDX_W;
  localparam int LPHT_N = 1 << LHIST_W;
  localparam int GPHT_N = 1 << GHIST_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

  logic [LHIST_W-1:0] lht  [LHT_N];
  logic [CTR_W-1:0]   lpht [LPHT_N];
  logic [CTR_W-1:0]   gpht [GPHT_N];
  logic [CTR_W-1:0]   ch   [GPHT_N];
  logic [GHIST_W-1:0] ghist;

  // Low PC bits, zero-extended when the PC is narrower than the index.
  function automatic logic [GHIST_W-1:0] pc_to_gidx(input logic [PC_W-1:0] pc);
    logic [GHIST_W-1:0] r;
    r = '0;
    for (int i = 0; i < GHIST_W && i < PC_W; i++) r[i] = pc[i];
    return r;
  endfunction

  function automatic logic [LHT_IDX_W-1:0] pc_to_lidx(input logic [PC_W-1:0] pc);
    logic [LHT_IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < LHT_IDX_W && i < PC_W; i++) r[i] = pc[i];
    return r;
  endfunction

  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
    if (up) return (c == CTR_MAX) ? c : c + CTR_W'(1);
    else    return (c == '0)      ? c : c - CTR_W'(1);
  endfunction

  // Prediction path, from pre-edge state.
  logic [LHT_IDX_W-1:0] p_lidx;
  logic [LHIST_W-1:0]   p_lhist;
  logic [GHIST_W-1:0]   p_gidx;
  logic                 p_lp, p_gp, p_sel;

  always_comb begin
    p_lidx  = pc_to_lidx(pred_pc_i);
    p_lhist = lht[p_lidx];
    p_gidx  = ghist ^ pc_to_gidx(pred_pc_i);
    p_lp    = lpht[p_lhist][CTR_W-1];
    p_gp    = gpht[p_gidx][CTR_W-1];
    p_sel   = ch[ghist][CTR_W-1];
  end

  // Update path: the component predictions are recomputed from current state
  // rather than carried from the original request.
  logic [LHT_IDX_W-1:0] u_lidx;
  logic [LHIST_W-1:0]   u_lhist;
  logic [GHIST_W-1:0]   u_gidx;
  logic                 u_lp, u_gp, u_taken;

  always_comb begin
    u_taken = (upd_target_i < upd_pc_i);
    u_lidx  = pc_to_lidx(upd_pc_i);
    u_lhist = lht[u_lidx];
    u_gidx  = ghist ^ pc_to_gidx(upd_pc_i);
    u_lp    = lpht[u_lhist][CTR_W-1];
    u_gp    = gpht[u_gidx][CTR_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LHT_N; i++)  lht[i]  <= '0;
      for (int i = 0; i < LPHT_N; i++) lpht[i] <= CTR_INIT;
      for (int i = 0; i < GPHT_N; i++) begin
        gpht[i] <= CTR_INIT;
        ch[i]   <= CTR_INIT;
      end
      ghist        <= '0;
      pred_valid_o <= 1'b0;
      pred_taken_o <= 1'b0;
      pred_src_o   <= 1'b0;
    end else begin
      pred_valid_o <= pred_valid_i;
      if (pred_valid_i) begin
        pred_taken_o <= p_sel ? p_gp : p_lp;
        pred_src_o   <= p_sel;
      end
      if (upd_valid_i) begin
        lpht[u_lhist] <= ctr_step(lpht[u_lhist], u_taken);
        gpht[u_gidx]  <= ctr_step(gpht[u_gidx], u_taken);
        // Chooser only learns when the components disagree; up means global was right.
        if (u_lp != u_gp) ch[ghist] <= ctr_step(ch[ghist], u_gp == u_taken);
        lht[u_lidx] <= {lht[u_lidx][LHIST_W-2:0], u_taken};
        ghist       <= {ghist[GHIST_W-2:0], u_taken};
      end
    end
  end

`ifdef TP_STATS_EN
  logic u_tour;
  assign u_tour = ch[ghist][CTR_W-1] ? u_gp : u_lp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_upd_o     <= '0;
      stat_mispred_o <= '0;
    end else if (upd_valid_i) begin
      if (stat_upd_o != 16'hFFFF) stat_upd_o <= stat_upd_o + 16'd1;
      if (u_tour != u_taken && stat_mispred_o != 16'hFFFF)
        stat_mispred_o <= stat_mispred_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tournament_predictor_param.sv
// tb/tb_tournament_predictor_param.sv - self-checking bench for tournament_predictor_param
module tb_tournament_predictor_param;

  localparam int PC_W = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pred_valid_i = 1'b0;
  logic [PC_W-1:0] pred_pc_i = '0;
  logic            pred_valid_o, pred_taken_o, pred_src_o;
  logic            upd_valid_i = 1'b0;
  logic [PC_W-1:0] upd_pc_i = '0;
  logic [PC_W-1:0] upd_target_i = '0;
`ifdef TP_STATS_EN
  logic [15:0]     stat_upd_o, stat_mispred_o;
`endif

  always #5 clk = ~clk;

  tournament_predictor_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pred_valid_i (pred_valid_i),
    .pred_pc_i    (pred_pc_i),
    .pred_valid_o (pred_valid_o),
    .pred_taken_o (pred_taken_o),
    .pred_src_o   (pred_src_o),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_target_i (upd_target_i)
`ifdef TP_STATS_EN
    ,
    .stat_upd_o     (stat_upd_o),
    .stat_mispred_o (stat_mispred_o)
`endif
  );

  int total = 0;
  int bad = 0;
  string cur = "none";
  bit [1:0] exp_q[$];

  // Reference model, written from the behavioural description with plain ints.
  int m_lht[8];
  int m_lpht[16];
  int m_gpht[16];
  int m_ch[16];
  int m_gh;
  int m_upd, m_mis;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_lht[i] = 0;
    for (int i = 0; i < 16; i++) begin
      m_lpht[i] = 1;
      m_gpht[i] = 1;
      m_ch[i] = 1;
    end
    m_gh = 0;
    m_upd = 0;
    m_mis = 0;
  endtask

  task automatic m_predict(input int pc, output bit tk, output bit sr);
    int lh, gi;
    bit lp, gp;
    lh = m_lht[pc % 8];
    gi = m_gh ^ (pc % 16);
    lp = (m_lpht[lh] >= 2);
    gp = (m_gpht[gi] >= 2);
    sr = (m_ch[m_gh] >= 2);
    tk = sr ? gp : lp;
  endtask

  task automatic m_update(input int pc, input int tgt);
    int lh, gi;
    bit lp, gp, sel, outc;
    outc = (tgt < pc);
    lh = m_lht[pc % 8];
    gi = m_gh ^ (pc % 16);
    lp = (m_lpht[lh] >= 2);
    gp = (m_gpht[gi] >= 2);
    sel = (m_ch[m_gh] >= 2);
    if (m_upd < 65535) m_upd++;
    if ((sel ? gp : lp) != outc && m_mis < 65535) m_mis++;
    m_lpht[lh] = outc ? ((m_lpht[lh] < 3) ? m_lpht[lh] + 1 : 3) : ((m_lpht[lh] > 0) ? m_lpht[lh] - 1 : 0);
    m_gpht[gi] = outc ? ((m_gpht[gi] < 3) ? m_gpht[gi] + 1 : 3) : ((m_gpht[gi] > 0) ? m_gpht[gi] - 1 : 0);
    if (lp != gp) begin
      if (gp == outc) m_ch[m_gh] = (m_ch[m_gh] < 3) ? m_ch[m_gh] + 1 : 3;
      else            m_ch[m_gh] = (m_ch[m_gh] > 0) ? m_ch[m_gh] - 1 : 0;
    end
    m_lht[pc % 8] = (m_lht[pc % 8] * 2 + int'(outc)) % 16;
    m_gh = (m_gh * 2 + int'(outc)) % 16;
  endtask

  // One clock: drive inputs just after an edge, sample 1 time unit after the next edge.
  task automatic step(input bit req, input int rpc, input bit upd, input int upc, input int utgt);
    bit tk, sr;
    bit [1:0] e;
    if (req) begin
      m_predict(rpc, tk, sr);
      exp_q.push_back({tk, sr});
    end
    if (upd) m_update(upc, utgt);
    pred_valid_i = req;
    pred_pc_i    = PC_W'(rpc);
    upd_valid_i  = upd;
    upd_pc_i     = PC_W'(upc);
    upd_target_i = PC_W'(utgt);
    @(posedge clk);
    #1;
    pred_valid_i = 1'b0;
    upd_valid_i  = 1'b0;
    total++;
    if (pred_valid_o !== req) begin
      bad++;
      $display("FAIL %s valid: got %b want %b", cur, pred_valid_o, req);
    end
    if (req) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL %s scoreboard: queue empty", cur);
      end else begin
        e = exp_q.pop_front();
        if ({pred_taken_o, pred_src_o} !== e) begin
          bad++;
          $display("FAIL %s pred pc=%0d: got taken=%b src=%b want taken=%b src=%b",
                   cur, rpc, pred_taken_o, pred_src_o, e[1], e[0]);
        end
      end
    end
  endtask

  task automatic do_reset();
    pred_valid_i = 1'b0;
    upd_valid_i  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cur = "reset";
    do_reset();
    step(1, 12, 1, 12, 9);
    step(1, 12, 0, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_reset();
    exp_q.delete();
    #1;
    total++;
    if ({pred_valid_o, pred_taken_o, pred_src_o} !== 3'b000) begin
      bad++;
      $display("FAIL reset outputs in reset: got %b%b%b want 000", pred_valid_o, pred_taken_o, pred_src_o);
    end
`ifdef TP_STATS_EN
    total++;
    if (stat_upd_o !== 16'd0) begin
      bad++;
      $display("FAIL reset stat_upd: got %0d want 0", stat_upd_o);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 12, 0, 0, 0);
    total++;
    if ({pred_valid_o, pred_taken_o, pred_src_o} !== 3'b100) begin
      bad++;
      $display("FAIL reset first request: got %b%b%b want 100", pred_valid_o, pred_taken_o, pred_src_o);
    end
  endtask

  task automatic test_pattern();
    bit [4:0] pat;
    bit outc;
    cur = "pattern";
    pat = 5'b01101;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 5; k++) begin
        outc = pat[k];
        step(1, 12, 0, 0, 0);
        if (p == 3) begin
          total++;
          if (pred_taken_o !== outc) begin
            bad++;
            $display("FAIL pattern period4 k=%0d: got %b want %b", k, pred_taken_o, outc);
          end
        end
        step(0, 0, 1, 12, outc ? 9 : 16);
      end
    end
`ifdef TP_STATS_EN
    total++;
    if (stat_upd_o !== 16'd20) begin
      bad++;
      $display("FAIL pattern stat_upd: got %0d want 20", stat_upd_o);
    end
    total++;
    if (stat_mispred_o !== 16'(m_mis)) begin
      bad++;
      $display("FAIL pattern stat_mispred: got %0d want %0d", stat_mispred_o, m_mis);
    end
`endif
  endtask

  task automatic test_hysteresis();
    cur = "hysteresis";
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 0, 1, 3, 1);
    step(1, 3, 1, 3, 31);
    total++;
    if (pred_taken_o !== 1'b1) begin
      bad++;
      $display("FAIL hysteresis pre-update: got %b want 1", pred_taken_o);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 1, 3, 1);
    step(1, 3, 0, 0, 0);
    total++;
    if (pred_taken_o !== 1'b1) begin
      bad++;
      $display("FAIL hysteresis weakened counter: got %b want 1", pred_taken_o);
    end
    step(0, 0, 0, 0, 0);
    total++;
    if (pred_taken_o !== 1'b1) begin
      bad++;
      $display("FAIL hysteresis hold: got %b want 1", pred_taken_o);
    end
  endtask

  task automatic test_same_cycle();
    cur = "same_cycle";
    do_reset();
    step(1, 5, 1, 5, 1);
    total++;
    if ({pred_taken_o, pred_src_o} !== 2'b00) begin
      bad++;
      $display("FAIL same_cycle pre-update view: got %b%b want 00", pred_taken_o, pred_src_o);
    end
    step(1, 6, 0, 0, 0);
    total++;
    if (pred_taken_o !== 1'b1) begin
      bad++;
      $display("FAIL same_cycle next request: got %b want 1", pred_taken_o);
    end
  endtask

  task automatic test_chooser();
    bit seen;
    int pc;
    cur = "chooser";
    seen = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pc = (i % 2 == 0) ? 1 : 9;
      step(1, pc, 0, 0, 0);
      if (pred_src_o === 1'b1) seen = 1'b1;
      step(0, 0, 1, pc, (i == 0) ? 0 : 31);
    end
    step(1, 1, 0, 0, 0);
    if (pred_src_o === 1'b1) seen = 1'b1;
    total++;
    if (seen !== 1'b1) begin
      bad++;
      $display("FAIL chooser global selected: got %b want 1", seen);
    end
  endtask

  task automatic test_equal();
    cur = "equal";
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 10, 10);
    step(1, 10, 0, 0, 0);
    total++;
    if (pred_taken_o !== 1'b0) begin
      bad++;
      $display("FAIL equal addresses: got %b want 0", pred_taken_o);
    end
  endtask

  task automatic test_back_to_back();
    int upc;
    cur = "back_to_back";
    do_reset();
    for (int i = 0; i < 60; i++) begin
      upc = int'($urandom_range(0, 31));
      step(1, int'($urandom_range(0, 31)), 1, upc,
           (i % 3 == 0) ? upc : int'($urandom_range(0, 31)));
    end
`ifdef TP_STATS_EN
    total++;
    if (stat_upd_o !== 16'(m_upd) || stat_mispred_o !== 16'(m_mis)) begin
      bad++;
      $display("FAIL back_to_back stats: got %0d/%0d want %0d/%0d", stat_upd_o, stat_mispred_o, m_upd, m_mis);
    end
`endif
  endtask

  initial begin
    m_reset();
    test_reset();
    test_pattern();
    test_hysteresis();
    test_same_cycle();
    test_chooser();
    test_equal();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
